// File: rtl/write_back_if.sv
// Commit-stage bus between execute/decode and write_back.
// Carries the commit request fields, the two operand read ports, and the
// architectural status outputs (pc, done, overrun, instret).
interface write_back_if #(
  parameter int unsigned CNT_W = 64
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned SW   = 4;

  logic             valid;
  logic [SW-1:0]    wselector;
  logic [XLEN-1:0]  data;
  logic [RW-1:0]    rd;
  logic [XLEN-1:0]  pc_target;
  logic [RW-1:0]    ra1;
  logic [RW-1:0]    ra2;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;
  logic [XLEN-1:0]  pc;
  logic             done;
  logic             overrun;
  logic [CNT_W-1:0] instret;

  // Execute/decode side: issues commits and reads operands.
  modport master (
    output valid, wselector, data, rd, pc_target, ra1, ra2,
    input  rd1, rd2, pc, done, overrun, instret
  );

  // Commit stage side.
  modport slave (
    input  valid, wselector, data, rd, pc_target, ra1, ra2,
    output rd1, rd2, pc, done, overrun, instret
  );
endinterface

// File: rtl/write_back.sv
// write_back: commit stage owning the 32x32 register file and the PC.
// A valid pulse in IDLE latches one execute result; the following edge
// writes the register file and/or redirects the PC and pulses done.
// Optional feature macro: WB_INSTRET_EN enables the retired-instruction
// counter; when undefined, instret is tied to zero.
module write_back #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'h0000_0004,
  parameter int unsigned CNT_W    = 64
) (
  input  logic         clk,
  input  logic         rst,
  write_back_if.slave  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned SW   = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   wsel_q, wsel_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            done_q, done_d;
  logic            overrun_q, overrun_d;
  logic            commit_c;
  logic            reg_we_c;

  logic [XLEN-1:0] regs_q [NREG];

  // Only bits [1] and [2] of the selector carry meaning.
  logic unused_wsel;
  assign unused_wsel = ^{wsel_q[3], wsel_q[0]};

  // Next-state, field latching, PC update and status outputs.
  always_comb begin
    state_d   = state_q;
    wsel_d    = wsel_q;
    data_d    = data_q;
    rd_d      = rd_q;
    tgt_d     = tgt_q;
    pc_d      = pc_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    commit_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid) begin
          wsel_d  = bus.wselector;
          data_d  = bus.data;
          rd_d    = bus.rd;
          tgt_d   = bus.pc_target;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        commit_c = 1'b1;
        done_d   = 1'b1;
        pc_d     = wsel_q[2] ? tgt_q : XLEN'(pc_q + PC_INC);
        state_d  = IDLE;
        // A request arriving while busy is dropped and flagged.
        if (bus.valid) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign reg_we_c = commit_c && wsel_q[1] && (rd_q != RW'(0));

  // Control/status state; reset discards any latched commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wsel_q    <= '0;
      data_q    <= '0;
      rd_q      <= '0;
      tgt_q     <= '0;
      pc_q      <= RESET_PC;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wsel_q    <= wsel_d;
      data_q    <= data_d;
      rd_q      <= rd_d;
      tgt_q     <= tgt_d;
      pc_q      <= pc_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Register file; entry 0 is only ever loaded with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (reg_we_c && (rd_q == RW'(i))) begin
          regs_q[i] <= data_q;
        end
      end
    end
  end

  // Asynchronous operand reads; no bypass of an in-flight commit.
  assign bus.rd1 = (bus.ra1 == RW'(0)) ? '0 : regs_q[bus.ra1];
  assign bus.rd2 = (bus.ra2 == RW'(0)) ? '0 : regs_q[bus.ra2];

  assign bus.pc      = pc_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  assign instret_d = commit_c ? CNT_W'(instret_q + CNT_W'(1)) : instret_q;

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign bus.instret = instret_q;
`else
  assign bus.instret = CNT_W'(0);
`endif

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: a table of directed commits issued
// back-to-back, plus hand sequences for overrun and reset mid-commit.
module tb_write_back;

  logic clk;
  logic rst;

  write_back_if #(.CNT_W(64)) bus ();

  write_back #(
    .RESET_PC(32'h0000_0000),
    .PC_INC  (32'h0000_0004),
    .CNT_W   (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int n_commit;

  typedef struct {
    logic [3:0]  wsel;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] tgt;
    logic [4:0]  ra1;
    logic [31:0] exp1;
    logic [4:0]  ra2;
    logic [31:0] exp2;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        tbl [8];
  logic [31:0] mdl [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret(input int n);
`ifdef WB_INSTRET_EN
    return 64'(n);
`else
    return 64'(0 * n);
`endif
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    n_commit = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

    //          wsel     rd     data          tgt           ra1 exp1          ra2 exp2          exp_pc
    tbl[0] = '{4'b0010, 5'd5,  32'hDEADBEEF, 32'h0000_0000, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        32'h0000_0004};
    tbl[1] = '{4'b0110, 5'd31, 32'h0000_0008, 32'h0000_0100, 5'd31, 32'h0000_0008, 5'd5,  32'hDEADBEEF, 32'h0000_0100};
    tbl[2] = '{4'b0010, 5'd0,  32'h0000_1234, 32'h0000_0000, 5'd0,  32'h0,        5'd31, 32'h0000_0008, 32'h0000_0104};
    tbl[3] = '{4'b0000, 5'd7,  32'h0000_0055, 32'h0000_0900, 5'd7,  32'h0,        5'd5,  32'hDEADBEEF, 32'h0000_0108};
    tbl[4] = '{4'b0100, 5'd6,  32'h0000_0099, 32'h0000_2000, 5'd6,  32'h0,        5'd31, 32'h0000_0008, 32'h0000_2000};
    tbl[5] = '{4'b1011, 5'd7,  32'h0000_CAFE, 32'h0000_3000, 5'd7,  32'h0000_CAFE, 5'd0,  32'h0,        32'h0000_2004};
    tbl[6] = '{4'b0110, 5'd5,  32'h1111_1111, 32'hFFFF_FFFC, 5'd5,  32'h1111_1111, 5'd7,  32'h0000_CAFE, 32'hFFFF_FFFC};
    tbl[7] = '{4'b0010, 5'd1,  32'h0000_A5A5, 32'h0000_0000, 5'd1,  32'h0000_A5A5, 5'd5,  32'h1111_1111, 32'h0000_0000};

    rst           = 1'b1;
    bus.valid     = 1'b0;
    bus.wselector = 4'h0;
    bus.data      = 32'h0;
    bus.rd        = 5'd0;
    bus.pc_target = 32'h0;
    bus.ra1       = 5'd0;
    bus.ra2       = 5'd0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_pc", 64'(bus.pc), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    chk("reset_overrun", 64'(bus.overrun), 64'h0);
    chk("reset_instret", bus.instret, 64'h0);
    for (int i = 0; i < 32; i++) begin
      bus.ra1 = 5'(i);
      bus.ra2 = 5'(31 - i);
      #1;
      chk("reset_rd1", 64'(bus.rd1), 64'h0);
      chk("reset_rd2", 64'(bus.rd2), 64'h0);
    end

    // Table: each commit issued in the cycle the previous done is high.
    for (int i = 0; i < 8; i++) begin
      bus.valid     = 1'b1;
      bus.wselector = tbl[i].wsel;
      bus.rd        = tbl[i].rd;
      bus.data      = tbl[i].data;
      bus.pc_target = tbl[i].tgt;
      bus.ra1       = tbl[i].ra1;
      bus.ra2       = tbl[i].ra2;
      @(negedge clk);
      bus.valid = 1'b0;
      bus.data  = 32'hFFFF_FFFF;
      chk("commit_done_early", 64'(bus.done), 64'h0);
      chk("commit_no_bypass", 64'(bus.rd1), 64'(mdl[tbl[i].ra1]));
      @(negedge clk);
      n_commit++;
      chk("commit_done", 64'(bus.done), 64'h1);
      chk("commit_rd1", 64'(bus.rd1), 64'(tbl[i].exp1));
      chk("commit_rd2", 64'(bus.rd2), 64'(tbl[i].exp2));
      chk("commit_pc", 64'(bus.pc), 64'(tbl[i].exp_pc));
      chk("commit_overrun", 64'(bus.overrun), 64'h0);
      chk("commit_instret", bus.instret, exp_instret(n_commit));
      mdl[tbl[i].ra1] = tbl[i].exp1;
    end

    // Overrun: valid held for two cycles; only the first commits.
    bus.valid     = 1'b1;
    bus.wselector = 4'b0010;
    bus.rd        = 5'd8;
    bus.data      = 32'h0000_0088;
    bus.ra1       = 5'd8;
    bus.ra2       = 5'd9;
    @(negedge clk);
    chk("ovr_clear_before", 64'(bus.overrun), 64'h0);
    bus.rd   = 5'd9;
    bus.data = 32'h0000_0077;
    @(negedge clk);
    bus.valid = 1'b0;
    n_commit++;
    chk("ovr_done", 64'(bus.done), 64'h1);
    chk("ovr_first_write", 64'(bus.rd1), 64'h88);
    chk("ovr_pc", 64'(bus.pc), 64'h4);
    chk("ovr_set", 64'(bus.overrun), 64'h1);
    @(negedge clk);
    chk("ovr_no_second_done", 64'(bus.done), 64'h0);
    chk("ovr_no_second_write", 64'(bus.rd2), 64'h0);
    chk("ovr_pc_hold", 64'(bus.pc), 64'h4);
    chk("ovr_instret", bus.instret, exp_instret(n_commit));
    repeat (3) @(negedge clk);
    chk("ovr_sticky", 64'(bus.overrun), 64'h1);

    // Reset asserted while a commit is in flight.
    bus.valid     = 1'b1;
    bus.wselector = 4'b0110;
    bus.rd        = 5'd10;
    bus.data      = 32'h0000_0BAD;
    bus.pc_target = 32'h0000_0500;
    bus.ra1       = 5'd10;
    bus.ra2       = 5'd8;
    @(negedge clk);
    bus.valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_commit = 0;
    chk("rst_pc", 64'(bus.pc), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_overrun", 64'(bus.overrun), 64'h0);
    chk("rst_instret", bus.instret, 64'h0);
    chk("rst_regs_cleared", 64'(bus.rd2), 64'h0);
    @(negedge clk);
    chk("rst_no_late_done", 64'(bus.done), 64'h0);
    chk("rst_no_write", 64'(bus.rd1), 64'h0);
    chk("rst_pc_hold", 64'(bus.pc), 64'h0);

    // Normal commit after reset.
    bus.valid     = 1'b1;
    bus.wselector = 4'b0010;
    bus.rd        = 5'd3;
    bus.data      = 32'h0000_0003;
    bus.ra1       = 5'd3;
    @(negedge clk);
    bus.valid = 1'b0;
    @(negedge clk);
    n_commit++;
    chk("post_done", 64'(bus.done), 64'h1);
    chk("post_rd1", 64'(bus.rd1), 64'h3);
    chk("post_pc", 64'(bus.pc), 64'h4);
    chk("post_instret", bus.instret, exp_instret(n_commit));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
